alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_divider.sv | 93 +++++++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the default
// divide-by-zero result code.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_CLR = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [15:0] ERROR_CODE_DEFAULT = 16'hDEAD;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge itself, so done pulses DATA_WIDTH-1 edges later.
module alu_divider
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] src_rem, src_quo, src_dvsr;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] diff;
  logic                  fits;
  logic [DATA_WIDTH-1:0] step_rem, step_quo;

  // One restoring step, fed either from fresh operands (start) or from the registers.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dvsr = start ? divisor : dvsr_q;
    trial    = {src_rem, src_quo[DATA_WIDTH-1]};
    fits     = (trial >= {1'b0, src_dvsr});
    diff     = trial[DATA_WIDTH-1:0] - src_dvsr;
    step_rem = fits ? diff : trial[DATA_WIDTH-1:0];
    step_quo = {src_quo[DATA_WIDTH-2:0], fits};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = step_rem;
      quo_d  = step_quo;
      dvsr_d = divisor;
      cnt_d  = CW'(DATA_WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops complete in one
// cycle, DIV runs on the iterative divider; the result is held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] ERROR_CODE = ERROR_CODE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                oper,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   res_out,
  output logic                      flag_zero,
  output logic                      flag_carry,
  output logic                      flag_err
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam logic [RW-1:0] ERR_RES = RW'(ERROR_CODE);

  state_e state_q, state_d;

  logic [RW-1:0] res_q, res_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;

  logic                  accept;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [DATA_WIDTH-1:0] div_quo;
  logic [DATA_WIDTH-1:0] div_rem;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [RW-1:0]         prod;
  logic [RW-1:0]         alu_res;
  logic                  alu_carry;
  logic                  alu_err;

  assign accept    = in_valid && in_ready;
  assign div_start = accept && (op_e'(oper) == OP_DIV) && (B != '0);

  alu_divider #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (A),
    .divisor  (B),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = div_start ? S_DIV : S_DONE;
      S_DIV:  if (div_done && !div_busy) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Single-cycle results; the DIV entry only matters for the B==0 case.
  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    diff      = A - B;
    prod      = {{DATA_WIDTH{1'b0}}, A} * {{DATA_WIDTH{1'b0}}, B};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_e'(oper))
      OP_CLR: alu_res = '0;
      OP_ADD: begin
        alu_res   = {{(DATA_WIDTH-1){1'b0}}, sum};
        alu_carry = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res   = {{DATA_WIDTH{1'b0}}, diff};
        alu_carry = (B > A);
      end
      OP_MUL: alu_res = prod;
      OP_DIV: begin
        alu_res = ERR_RES;
        alu_err = 1'b1;
      end
      OP_AND: alu_res = {{DATA_WIDTH{1'b0}}, A & B};
      OP_OR:  alu_res = {{DATA_WIDTH{1'b0}}, A | B};
      OP_XOR: alu_res = {{DATA_WIDTH{1'b0}}, A ^ B};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    if (accept && !div_start) begin
      res_d   = alu_res;
      zero_d  = (alu_res == '0);
      carry_d = alu_carry;
      err_d   = alu_err;
    end else if ((state_q == S_DIV) && div_done) begin
      res_d   = {div_rem, div_quo};
      zero_d  = ({div_rem, div_quo} == '0);
      carry_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign res_out    = res_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_err   = err_q;

endmodule
